// File: rtl/sm_key_debounce.sv
// sm_key_debounce: synchronizes and debounces N raw push-buttons.
// For each key it produces a clean level, one-cycle press/release pulses,
// and optional auto-repeat pulses while the key is held.
// Each key has its own synchronizer, debounce FSM and repeat counter.
// The keys do not interact, so events on several keys can pulse in the same cycle.
module sm_key_debounce #(
  parameter int N            = 4,
  parameter int CNT_W        = 20,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE     = 50000,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_raw,
  input  logic         repeat_en,
  output logic [N-1:0] key_level,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_repeat
);

  // Raw pin level while the key is not pressed.
  // The synchronizer loads this level on reset, so a key that is held
  // through reset is seen as a fresh press.
  localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Terminal counts. Counters are compared with == and are cleared at
  // the limit, so they never run past it.
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHK,
    ST_HELD,
    ST_RELEASE_CHK
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             pressed;
      state_t           state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] rcnt_reg;
      logic             rate_phase_reg;
      logic             level_reg;
      logic             press_reg;
      logic             release_reg;
      logic             repeat_reg;

      // Remove the board polarity: 1 means the key is pressed.
      assign pressed = sync2_reg ^ INACTIVE;

      // Synchronizer, debounce FSM and auto-repeat timer for one key.
      // All outputs are registered.
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg      <= INACTIVE;
          sync2_reg      <= INACTIVE;
          state_reg      <= ST_IDLE;
          cnt_reg        <= '0;
          rcnt_reg       <= '0;
          rate_phase_reg <= 1'b0;
          level_reg      <= 1'b0;
          press_reg      <= 1'b0;
          release_reg    <= 1'b0;
          repeat_reg     <= 1'b0;
        end else begin
          sync1_reg   <= key_raw[gi];
          sync2_reg   <= sync1_reg;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          repeat_reg  <= 1'b0;
          case (state_reg)
            ST_IDLE: begin
              if (pressed) begin
                state_reg <= ST_PRESS_CHK;
                cnt_reg   <= '0;
              end
            end
            ST_PRESS_CHK: begin
              if (!pressed) begin
                state_reg <= ST_IDLE;
              end else if (cnt_reg == DB_LAST) begin
                state_reg      <= ST_HELD;
                level_reg      <= 1'b1;
                press_reg      <= 1'b1;
                rcnt_reg       <= '0;
                rate_phase_reg <= 1'b0;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            ST_HELD: begin
              if (!pressed) begin
                // Leaving HELD restarts the repeat sequence from the long delay.
                state_reg      <= ST_RELEASE_CHK;
                cnt_reg        <= '0;
                rcnt_reg       <= '0;
                rate_phase_reg <= 1'b0;
              end else if (!repeat_en) begin
                rcnt_reg       <= '0;
                rate_phase_reg <= 1'b0;
              end else if (rcnt_reg == (rate_phase_reg ? RATE_LAST : DELAY_LAST)) begin
                repeat_reg     <= 1'b1;
                rcnt_reg       <= '0;
                rate_phase_reg <= 1'b1;
              end else begin
                rcnt_reg <= rcnt_reg + 1'b1;
              end
            end
            ST_RELEASE_CHK: begin
              if (pressed) begin
                // The release was a glitch. Go back to HELD; rcnt was
                // already cleared on the way out.
                state_reg <= ST_HELD;
              end else if (cnt_reg == DB_LAST) begin
                state_reg   <= ST_IDLE;
                level_reg   <= 1'b0;
                release_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            default: begin
              state_reg <= ST_IDLE;
            end
          endcase
        end
      end

      assign key_level[gi]   = level_reg;
      assign key_press[gi]   = press_reg;
      assign key_release[gi] = release_reg;
      assign key_repeat[gi]  = repeat_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sm_key_debounce.sv
// Testbench for sm_key_debounce.
// A behavioural model turns every sampled input cycle into an expected
// output vector and queues it. A monitor compares each queued vector
// against the DUT outputs on the following falling edge.
// Directed checks measure the edge latencies named for press, release,
// repeat and reset.
module tb_sm_key_debounce;
  localparam int N  = 4;
  localparam int CW = 20;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         repeat_en;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_level, key_press, key_release, key_repeat;

  always #5 clk = ~clk;

  sm_key_debounce #(
    .N(N), .CNT_W(CW), .ACTIVE_LOW(1), .DEBOUNCE(D),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Model state, kept per key:
  //   m_l     accepted level
  //   m_run   length of the current run of samples that differ from m_l
  //   m_cnt   held cycles with repeat enabled since the last repeat event
  //   m_first 1 while still waiting for the first, long repeat delay
  logic [N-1:0] m_p1, m_p2, m_l;
  int           m_run[N];
  int           m_cnt[N];
  bit           m_first[N];

  // Reference model.
  // The debounce engine sees each raw sample two edges later.
  // A change is accepted when D+1 consecutive samples differ from the
  // accepted level.
  // A stable held key repeats RD enabled cycles after the press, then
  // every RR cycles after that.
  always @(posedge clk) begin : model
    exp_t         e;
    logic [N-1:0] s;
    bit           was_held;
    e = '0;
    if (rst) begin
      m_l  = '0;
      m_p1 = '0;
      m_p2 = '0;
      for (int k = 0; k < N; k++) begin
        m_run[k]   = 0;
        m_cnt[k]   = 0;
        m_first[k] = 1'b1;
      end
    end else begin
      s = m_p2;
      for (int k = 0; k < N; k++) begin
        if (s[k] != m_l[k]) begin
          m_run[k]   = m_run[k] + 1;
          m_cnt[k]   = 0;
          m_first[k] = 1'b1;
          if (m_run[k] == D + 1) begin
            m_l[k]   = ~m_l[k];
            m_run[k] = 0;
            if (m_l[k]) e.prs[k] = 1'b1;
            else        e.rel[k] = 1'b1;
          end
        end else begin
          was_held = m_l[k] && (m_run[k] == 0);
          m_run[k] = 0;
          if (was_held) begin
            if (!repeat_en) begin
              m_cnt[k]   = 0;
              m_first[k] = 1'b1;
            end else begin
              m_cnt[k] = m_cnt[k] + 1;
              if (m_cnt[k] == (m_first[k] ? RD : RR)) begin
                e.rpt[k]   = 1'b1;
                m_cnt[k]   = 0;
                m_first[k] = 1'b0;
              end
            end
          end
        end
      end
      m_p2 = m_p1;
      m_p1 = ~key_raw;
      e.lvl = m_l;
    end
    exp_q.push_back(e);
  end

  function automatic void chk(string name, logic [N-1:0] act, logic [N-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end
  endfunction

  // Monitor: on each falling edge, pop one expected vector and compare
  // it with the DUT outputs.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("key_level",   key_level,   e.lvl);
      chk("key_press",   key_press,   e.prs);
      chk("key_release", key_release, e.rel);
      chk("key_repeat",  key_repeat,  e.rpt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the chosen pulse appears on key k, then compares
  // that count with the required latency.
  // kind: 0 = press, 1 = release, 2 = repeat.
  task automatic measure(input int k, input int kind, input int want, input string nm);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      case (kind)
        0:       seen = key_press[k];
        1:       seen = key_release[k];
        default: seen = key_repeat[k];
      endcase
    end
    compared++;
    if (!seen || n != want) begin
      mismatched++;
      $display("FAIL %s latency actual=%0d seen=%0d required=%0d", nm, n, seen, want);
    end
  endtask

  initial begin : driver
    rst       = 1'b1;
    key_raw   = '1;
    repeat_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Press key 0, then release it.
    key_raw[0] = 1'b0;
    measure(0, 0, 7, "press_k0");
    chk("level_k0_after_press", key_level, 4'b0001);
    repeat (3) tick();
    key_raw[0] = 1'b1;
    measure(0, 1, 7, "release_k0");

    // Hold key 0, inject a one-cycle glitch while HELD, then release it.
    key_raw[0] = 1'b0;
    measure(0, 0, 7, "press_k0_again");
    key_raw[0] = 1'b1;
    tick();
    key_raw[0] = 1'b0;
    repeat (10) tick();
    chk("level_k0_after_glitch", key_level, 4'b0001);
    key_raw[0] = 1'b1;
    repeat (10) tick();

    // Bounce on key 1: low for 3 cycles, high for 1, then low and held.
    key_raw[1] = 1'b0;
    repeat (3) tick();
    key_raw[1] = 1'b1;
    tick();
    key_raw[1] = 1'b0;
    measure(1, 0, 7, "press_k1_bounce");
    key_raw[1] = 1'b1;
    repeat (10) tick();

    // Auto-repeat on key 2, then disable it while the key is still held.
    repeat_en  = 1'b1;
    key_raw[2] = 1'b0;
    measure(2, 0, 7, "press_k2");
    measure(2, 2, 8, "repeat_k2_first");
    measure(2, 2, 3, "repeat_k2_second");
    measure(2, 2, 3, "repeat_k2_third");
    repeat_en = 1'b0;
    repeat (20) tick();
    key_raw[2] = 1'b1;
    repeat (10) tick();

    // Press keys 0 and 3 on the same edge.
    key_raw[0] = 1'b0;
    key_raw[3] = 1'b0;
    measure(0, 0, 7, "press_k0_simul");
    chk("press_simul", key_press, 4'b1001);
    key_raw = '1;
    repeat (10) tick();

    // Reset while key 1 is in PRESS_CHK.
    key_raw[1] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rst_press_chk_level", key_level, 4'b0000);
    chk("rst_press_chk_press", key_press, 4'b0000);
    rst = 1'b0;
    measure(1, 0, 7, "press_k1_after_rst");

    // Reset while key 1 is in HELD, with repeat enabled.
    repeat_en = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("rst_held_level",  key_level,  4'b0000);
    chk("rst_held_repeat", key_repeat, 4'b0000);
    rst = 1'b0;
    measure(1, 0, 7, "press_k1_after_rst2");
    key_raw = '1;
    repeat (10) tick();

    // Random traffic: key flips, repeat_en changes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, (c < 1500) ? 4 : 14) == 0) key_raw[k] = ~key_raw[k];
      end
      if ($urandom_range(0, 60) == 0) repeat_en = ~repeat_en;
      rst = ($urandom_range(0, 400) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
